// File: rtl/seg7_pkg.sv
// Segment bit positions and glyph constants shared by the scan driver.
// Pure constants, no latency.
// No flow control.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Single lit segment; glyphs are built as unions of these.
  function automatic logic [7:0] seg_on(int b);
    return 8'(1) << b;
  endfunction

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_0 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F);
  localparam logic [7:0] GLYPH_1 = seg_on(SEG_B) | seg_on(SEG_C);
  localparam logic [7:0] GLYPH_2 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_3 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_4 = seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_5 = seg_on(SEG_A) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_6 = seg_on(SEG_A) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_7 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C);
  localparam logic [7:0] GLYPH_8 = GLYPH_0 | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_9 = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_A = seg_on(SEG_A) | seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_E) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_B = seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_C = seg_on(SEG_A) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F);
  localparam logic [7:0] GLYPH_D = seg_on(SEG_B) | seg_on(SEG_C) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_E = seg_on(SEG_A) | seg_on(SEG_D) | seg_on(SEG_E) | seg_on(SEG_F) | seg_on(SEG_G);
  localparam logic [7:0] GLYPH_F = seg_on(SEG_A) | seg_on(SEG_E) | seg_on(SEG_F) | seg_on(SEG_G);

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-facing bundle of the scan driver: value/dp/control in, pins out.
// No latency of its own.
// No flow control; load is a single-cycle strobe.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic                  lz_blank;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output en, load, value, dp, lz_blank,
    input  seg, an, frame_done
  );

  modport slave (
    input  en, load, value, dp, lz_blank,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg7_glyph.sv
// Nibble to 7-segment glyph decode; the only decode point in the driver.
// Combinational, zero latency.
// No flow control.
module seg7_glyph
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Values 10..15 decode to A..F only in hex builds, otherwise blank.
  always_comb begin
    glyph = GLYPH_BLANK[6:0];
    case (nibble)
      4'h0: glyph = GLYPH_0[6:0];
      4'h1: glyph = GLYPH_1[6:0];
      4'h2: glyph = GLYPH_2[6:0];
      4'h3: glyph = GLYPH_3[6:0];
      4'h4: glyph = GLYPH_4[6:0];
      4'h5: glyph = GLYPH_5[6:0];
      4'h6: glyph = GLYPH_6[6:0];
      4'h7: glyph = GLYPH_7[6:0];
      4'h8: glyph = GLYPH_8[6:0];
      4'h9: glyph = GLYPH_9[6:0];
      4'hA: if (HEX_EN) glyph = GLYPH_A[6:0];
      4'hB: if (HEX_EN) glyph = GLYPH_B[6:0];
      4'hC: if (HEX_EN) glyph = GLYPH_C[6:0];
      4'hD: if (HEX_EN) glyph = GLYPH_D[6:0];
      4'hE: if (HEX_EN) glyph = GLYPH_E[6:0];
      4'hF: if (HEX_EN) glyph = GLYPH_F[6:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with tear-free double-buffered value.
// Outputs registered; a load shows up at the next frame boundary.
// No backpressure; back-to-back loads within a frame keep the last one.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter bit HEX_EN   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]        pre, pre_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 running;
  logic                 boundary;
  logic                 direct_load;

  logic [4*DIGITS-1:0]  pend_value, shadow_value, shadow_value_nxt;
  logic [DIGITS-1:0]    pend_dp, shadow_dp, shadow_dp_nxt;
  logic                 pend;

  logic [DIGITS-1:0]    zero_above;
  logic                 all_zero;
  logic [3:0]           nib;
  logic [6:0]           glyph;
  logic                 hide;
  logic [7:0]           seg_nxt;

  logic [7:0]           seg_q;
  logic [DIGITS-1:0]    an_q;
  logic                 frame_done_q;

  // The frame boundary is the digit-0 ghost-guard cycle of a running scan.
  // Outside a running scan a load goes straight to the shadow set.
  always_comb begin
    boundary    = running && (pre == '0) && (idx == '0);
    direct_load = bus.load && (!bus.en || !running || boundary);
  end

  // Shadow next-state; the output stage decodes from this so a boundary
  // update is already visible in the first lit cycle of digit 0.
  always_comb begin
    shadow_value_nxt = shadow_value;
    shadow_dp_nxt    = shadow_dp;
    if (direct_load) begin
      shadow_value_nxt = bus.value;
      shadow_dp_nxt    = bus.dp;
    end else if (bus.en && boundary && pend) begin
      shadow_value_nxt = pend_value;
      shadow_dp_nxt    = pend_dp;
    end
  end

  // Advance prescaler; the digit index steps when the prescaler wraps.
  always_comb begin
    pre_nxt = (pre == PRE_LAST) ? '0 : pre + PW'(1);
    idx_nxt = idx;
    if (pre == PRE_LAST) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Leading-zero mask and segment pattern for the digit about to be lit.
  always_comb begin
    zero_above = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero && (shadow_value_nxt[4*i +: 4] == 4'h0);
      zero_above[i] = all_zero;
    end
    nib     = shadow_value_nxt[4*idx_nxt +: 4];
    hide    = bus.lz_blank && (idx_nxt != '0) && zero_above[idx_nxt];
    seg_nxt = {1'b0, hide ? 7'h00 : glyph};
    seg_nxt[SEG_DP] = shadow_dp_nxt[idx_nxt];
  end

  seg7_glyph #(.HEX_EN(HEX_EN)) u_glyph (
    .nibble (nib),
    .glyph  (glyph)
  );

  // Pending and shadow register sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value   <= '0;
      pend_dp      <= '0;
      pend         <= 1'b0;
      shadow_value <= '0;
      shadow_dp    <= '0;
    end else begin
      shadow_value <= shadow_value_nxt;
      shadow_dp    <= shadow_dp_nxt;
      if (bus.load) begin
        if (direct_load) begin
          pend <= 1'b0;
        end else begin
          pend_value <= bus.value;
          pend_dp    <= bus.dp;
          pend       <= 1'b1;
        end
      end else if (bus.en && boundary) begin
        pend <= 1'b0;
      end
    end
  end

  // Scan position and registered pin outputs; a fresh start lands on the
  // digit-0 ghost-guard cycle and counts as a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running      <= 1'b0;
      pre          <= '0;
      idx          <= '0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else if (!bus.en) begin
      running      <= 1'b0;
      pre          <= '0;
      idx          <= '0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else if (!running) begin
      running      <= 1'b1;
      pre          <= '0;
      idx          <= '0;
      seg_q        <= '0;
      an_q         <= '0;
      frame_done_q <= 1'b1;
    end else begin
      pre <= pre_nxt;
      idx <= idx_nxt;
      if (pre_nxt == '0) begin
        seg_q        <= '0;
        an_q         <= '0;
        frame_done_q <= (idx_nxt == '0);
      end else begin
        seg_q        <= seg_nxt;
        an_q         <= DIGITS'(1) << idx_nxt;
        frame_done_q <= 1'b0;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: hex-off and hex-on builds driven in lockstep
// and compared every cycle against a frame-position reference model.
// Directed scenarios first, then randomized traffic.
module tb_seg7_scan_driver;

  localparam int D  = 4;
  localparam int S  = 4;
  localparam int FR = D * S;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp = '0;
  logic          lz = 1'b0;

  seg7_scan_driver_if #(.DIGITS(D)) bus0 ();
  seg7_scan_driver_if #(.DIGITS(D)) bus1 ();

  assign bus0.en = en;  assign bus0.load = load;  assign bus0.value = value;
  assign bus0.dp = dp;  assign bus0.lz_blank = lz;
  assign bus1.en = en;  assign bus1.load = load;  assign bus1.value = value;
  assign bus1.dp = dp;  assign bus1.lz_blank = lz;

  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .HEX_EN(1'b0)) dut_dec (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S), .HEX_EN(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position in the frame as one counter 0..FR-1.
  logic [7:0]  gtab [16];
  bit          m_run;
  int          m_t;
  logic [15:0] m_shadow, m_pval;
  logic [3:0]  m_sdp, m_pdp;
  bit          m_pend;
  logic [7:0]  e_seg_dec, e_seg_hex;
  logic [3:0]  e_an;
  logic        e_fd;

  function automatic logic [7:0] ref_glyph(input logic [3:0] n, input bit hex);
    if (n < 4'd10 || hex) return gtab[n];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_shadow = '0; m_pval = '0; m_sdp = '0; m_pdp = '0;
    m_pend = 0; e_seg_dec = '0; e_seg_hex = '0; e_an = '0; e_fd = 1'b0;
  endtask

  task automatic model_step();
    int slot;
    logic [3:0] nib;
    bit hidden;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!en || !m_run) begin
      if (load) begin m_shadow = value; m_sdp = dp; m_pend = 0; end
      m_run = en; m_t = 0;
      e_an = '0; e_seg_dec = '0; e_seg_hex = '0; e_fd = en;
      return;
    end
    if (load) begin
      if (m_t == 0) begin m_shadow = value; m_sdp = dp; m_pend = 0; end
      else begin m_pval = value; m_pdp = dp; m_pend = 1; end
    end else if (m_t == 0 && m_pend) begin
      m_shadow = m_pval; m_sdp = m_pdp; m_pend = 0;
    end
    m_t  = (m_t + 1) % FR;
    slot = m_t / S;
    if (m_t % S == 0) begin
      e_an = '0; e_seg_dec = '0; e_seg_hex = '0; e_fd = (slot == 0);
    end else begin
      e_an   = 4'(1 << slot);
      e_fd   = 1'b0;
      nib    = 4'(m_shadow >> (4 * slot));
      hidden = lz && slot > 0 && ((m_shadow >> (4 * slot)) == 16'h0);
      e_seg_dec = hidden ? 8'h00 : ref_glyph(nib, 0);
      e_seg_hex = hidden ? 8'h00 : ref_glyph(nib, 1);
      if (m_sdp[slot]) begin
        e_seg_dec = e_seg_dec | 8'h80;
        e_seg_hex = e_seg_hex | 8'h80;
      end
    end
  endtask

  task automatic compare_all();
    check("seg_dec", bus0.seg, e_seg_dec);
    check("seg_hex", bus1.seg, e_seg_hex);
    check("an_dec",  bus0.an,  e_an);
    check("an_hex",  bus1.an,  e_an);
    check("fd_dec",  bus0.frame_done, e_fd);
    check("fd_hex",  bus1.frame_done, e_fd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Bounded walk to a frame position; ends after one frame regardless.
  task automatic run_to(input int t);
    for (int i = 0; i <= FR && !(m_run && m_t == t); i++) cycle();
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if ($urandom_range(1, 0) == 1) v[4*i +: 4] = 4'($urandom);
    return v;
  endfunction

  initial begin
    int last;
    gtab[0]  = 8'h3F; gtab[1]  = 8'h06; gtab[2]  = 8'h5B; gtab[3]  = 8'h4F;
    gtab[4]  = 8'h66; gtab[5]  = 8'h6D; gtab[6]  = 8'h7D; gtab[7]  = 8'h07;
    gtab[8]  = 8'h7F; gtab[9]  = 8'h67; gtab[10] = 8'h77; gtab[11] = 8'h7C;
    gtab[12] = 8'h39; gtab[13] = 8'h5E; gtab[14] = 8'h79; gtab[15] = 8'h71;
    model_reset();

    // Reset state.
    #1 compare_all();
    @(negedge clk); compare_all();
    @(negedge clk); rst_n = 1'b1;

    // First edge after reset: digit-0 guard with frame_done; load 1234 there.
    cycle();
    check("start_fd", bus0.frame_done, 1'b1);
    do_load(16'h1234, 4'h0);
    last = -1;
    for (int k = 0; k < 3 * FR; k++) begin
      cycle();
      if (bus0.frame_done) begin
        if (last >= 0) check("fd_period", k - last, FR);
        last = k;
      end
    end

    // Mid-frame load: held back until the next boundary.
    run_to(5);
    do_load(16'h5678, 4'h0);
    run(2 * FR);

    // Leading-zero suppression with a dp on a suppressed digit.
    lz = 1'b1;
    run_to(7);
    do_load(16'h0007, 4'b0100);
    run(2 * FR);
    lz = 1'b0;

    // Hex glyphs vs blanks.
    do_load(16'hFA00, 4'h0);
    run(2 * FR);

    // Load during the frame_done cycle lands in the same frame's digit 0.
    run_to(0);
    do_load(16'h9876, 4'h0);
    check("lfd_seg", bus0.seg, 8'h7D);
    check("lfd_an", bus0.an, 4'h1);
    run(FR);

    // Asynchronous reset mid-frame.
    run_to(6);
    async_reset_pulse();
    run(FR + 3);

    // en low mid-frame, direct load while dark, then restart.
    run_to(9);
    en = 1'b0;
    cycle();
    do_load(16'h4321, 4'h1);
    run(3);
    en = 1'b1;
    cycle();
    check("restart_fd", bus1.frame_done, 1'b1);
    run(2 * FR);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      load  = ($urandom_range(5, 0) == 0);
      value = rand_value();
      dp    = 4'($urandom);
      if ($urandom_range(15, 0) == 0) lz = ~lz;
      if ($urandom_range(39, 0) == 0) en = ~en;
      else if (!en && $urandom_range(3, 0) == 0) en = 1'b1;
      if ($urandom_range(499, 0) == 0) begin
        load = 1'b0;
        async_reset_pulse();
      end else begin
        cycle();
      end
    end
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
